// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-lane demand-driven traffic light controller
// Optional emergency all-red hold is enabled by defining TLC_EMERGENCY_EN.

package car_types_pkg;
    typedef logic [3:0] car_counter_t;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } strafic_light_t;
endpackage

module traffic_light_ctrl
    import car_types_pkg::*;
#(
    parameter int MIN_GREEN      = 8,
    parameter int MAX_GREEN      = 32,
    parameter int YELLOW_CYCLES  = 4,
    parameter int ALL_RED_CYCLES = 2,
    parameter int CROSS_PERIOD   = 4
) (
    input  logic           clk,
    input  logic           rst,
`ifdef TLC_EMERGENCY_EN
    input  logic           emergency,
`endif
    input  car_counter_t   car_counter_a,
    input  car_counter_t   car_counter_b,
    output strafic_light_t light_a,
    output strafic_light_t light_b,
    output logic           cross_a,
    output logic           cross_b
);

    localparam logic [2:0] S_A_GREEN   = 3'd0;
    localparam logic [2:0] S_A_YELLOW  = 3'd1;
    localparam logic [2:0] S_RED_AB    = 3'd2;
    localparam logic [2:0] S_B_GREEN   = 3'd3;
    localparam logic [2:0] S_B_YELLOW  = 3'd4;
    localparam logic [2:0] S_RED_BA    = 3'd5;
`ifdef TLC_EMERGENCY_EN
    localparam logic [2:0] S_EMERG_RED = 3'd6;
`endif

    localparam int TLIM_0 = (MAX_GREEN > MIN_GREEN) ? MAX_GREEN : MIN_GREEN;
    localparam int TLIM_1 = (TLIM_0 > YELLOW_CYCLES) ? TLIM_0 : YELLOW_CYCLES;
    localparam int TLIM_2 = (TLIM_1 > ALL_RED_CYCLES) ? TLIM_1 : ALL_RED_CYCLES;
    localparam int TLIM   = (TLIM_2 > 2) ? TLIM_2 - 1 : 1;
    localparam int TW     = $clog2(TLIM + 1);
    localparam int CW     = $clog2(CROSS_PERIOD);

    localparam logic [TW-1:0] T_SAT = TW'(TLIM);
    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] T_RED = TW'(ALL_RED_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(CROSS_PERIOD - 1);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [TW-1:0] timer;
    logic [CW-1:0] phase;
    logic          timer_clear;
    logic          busy_a;
    logic          busy_b;
    logic          cross_a_d;
    logic          cross_b_d;

    assign busy_a = (car_counter_a != '0);
    assign busy_b = (car_counter_b != '0);

    function automatic logic green_exit(input logic [TW-1:0] t,
                                        input logic own_busy,
                                        input logic other_busy);
        return other_busy && (t >= T_MIN) && (!own_busy || (t >= T_MAX));
    endfunction

    function automatic strafic_light_t lane_light(input logic [2:0] s,
                                                  input logic [2:0] s_green,
                                                  input logic [2:0] s_yellow);
        if (s == s_green)
            return GREEN;
        else if (s == s_yellow)
            return YELLOW;
        else
            return RED;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            S_A_GREEN:  if (green_exit(timer, busy_a, busy_b)) next_state = S_A_YELLOW;
            S_A_YELLOW: if (timer == T_YEL) next_state = S_RED_AB;
            S_RED_AB:   if (timer == T_RED) next_state = S_B_GREEN;
            S_B_GREEN:  if (green_exit(timer, busy_b, busy_a)) next_state = S_B_YELLOW;
            S_B_YELLOW: if (timer == T_YEL) next_state = S_RED_BA;
            S_RED_BA:   if (timer == T_RED) next_state = S_A_GREEN;
`ifdef TLC_EMERGENCY_EN
            S_EMERG_RED:
                if (timer == T_RED)
                    next_state = (car_counter_b > car_counter_a) ? S_B_GREEN : S_A_GREEN;
`endif
            default:    next_state = S_RED_BA;
        endcase
`ifdef TLC_EMERGENCY_EN
        // Yellow still runs to completion; everything else heads for the all-red hold.
        if (emergency) begin
            case (state)
                S_A_GREEN:  next_state = S_A_YELLOW;
                S_B_GREEN:  next_state = S_B_YELLOW;
                S_A_YELLOW,
                S_B_YELLOW: next_state = (timer == T_YEL) ? S_EMERG_RED : state;
                default:    next_state = S_EMERG_RED;
            endcase
        end
`endif
    end

`ifdef TLC_EMERGENCY_EN
    assign timer_clear = (next_state != state) || ((state == S_EMERG_RED) && emergency);
`else
    assign timer_clear = (next_state != state);
`endif

    // Separate wrapping phase keeps the cross cadence alive after the timer saturates.
    assign cross_a_d = (state == S_A_GREEN) && busy_a && (phase == P_LAST) && (next_state == state);
    assign cross_b_d = (state == S_B_GREEN) && busy_b && (phase == P_LAST) && (next_state == state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RED_BA;
            timer   <= '0;
            phase   <= '0;
            light_a <= RED;
            light_b <= RED;
            cross_a <= 1'b0;
            cross_b <= 1'b0;
        end else begin
            state   <= next_state;
            light_a <= lane_light(next_state, S_A_GREEN, S_A_YELLOW);
            light_b <= lane_light(next_state, S_B_GREEN, S_B_YELLOW);
            cross_a <= cross_a_d;
            cross_b <= cross_b_d;
            if (timer_clear) begin
                timer <= '0;
                phase <= '0;
            end else begin
                if (timer != T_SAT)
                    timer <= timer + 1'b1;
                phase <= (phase == P_LAST) ? '0 : phase + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized bench for traffic_light_ctrl against a phase-sequence model
module tb_traffic_light_ctrl;
    import car_types_pkg::*;

    localparam int MIN_G = 8;
    localparam int MAX_G = 32;
    localparam int YEL   = 4;
    localparam int ARED  = 2;
    localparam int CP    = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    car_counter_t   car_counter_a = '0;
    car_counter_t   car_counter_b = '0;
    strafic_light_t light_a;
    strafic_light_t light_b;
    logic           cross_a;
    logic           cross_b;
`ifdef TLC_EMERGENCY_EN
    logic           emergency = 1'b0;
`endif

    traffic_light_ctrl #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYCLES(YEL),
        .ALL_RED_CYCLES(ARED), .CROSS_PERIOD(CP)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef TLC_EMERGENCY_EN
        .emergency(emergency),
`endif
        .car_counter_a(car_counter_a),
        .car_counter_b(car_counter_b),
        .light_a(light_a),
        .light_b(light_b),
        .cross_a(cross_a),
        .cross_b(cross_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Phases in rotation order: 0 A green, 1 A yellow, 2 red A->B, 3 B green, 4 B yellow, 5 red B->A.
    int ph = 5;
    int age = 0;
    bit exp_ca = 0;
    bit exp_cb = 0;
    int green_cycles_a = 0;

    task automatic model_step(input bit r, input int ca, input int cb);
        int own;
        int oth;
        bit leave;
        if (r) begin
            ph = 5; age = 0; exp_ca = 0; exp_cb = 0;
            return;
        end
        leave = 0;
        case (ph % 3)
            0: begin
                own = (ph == 0) ? ca : cb;
                oth = (ph == 0) ? cb : ca;
                leave = (age >= MIN_G - 1) && (oth > 0) && (own == 0 || age >= MAX_G - 1);
            end
            1: leave = (age + 1 >= YEL);
            default: leave = (age + 1 >= ARED);
        endcase
        exp_ca = (ph == 0) && (ca > 0) && (age % CP == CP - 1) && !leave;
        exp_cb = (ph == 3) && (cb > 0) && (age % CP == CP - 1) && !leave;
        if (leave) begin
            ph = (ph + 1) % 6;
            age = 0;
        end else begin
            age++;
        end
    endtask

    function automatic int exp_light(input int p, input bit lane_b);
        int g;
        g = lane_b ? 3 : 0;
        if (p == g) return int'(GREEN);
        if (p == g + 1) return int'(YELLOW);
        return int'(RED);
    endfunction

    task automatic cycle(input bit r, input int ca, input int cb);
        rst = r;
        car_counter_a = car_counter_t'(ca);
        car_counter_b = car_counter_t'(cb);
        @(posedge clk);
        model_step(r, ca, cb);
        @(negedge clk);
        check("light_a", int'(light_a), exp_light(ph, 1'b0));
        check("light_b", int'(light_b), exp_light(ph, 1'b1));
        check("cross_a", int'(cross_a), int'(exp_ca));
        check("cross_b", int'(cross_b), int'(exp_cb));
        check("cross_excl", int'(cross_a & cross_b), 0);
        if (cross_a) check("cross_a_green", int'(light_a), int'(GREEN));
        if (cross_b) check("cross_b_green", int'(light_b), int'(GREEN));
    endtask

    function automatic int rand_count();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
    endfunction

    initial begin
        int ca;
        int cb;
        int len;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 0);
        cycle(1'b0, 0, 0);
        check("green_after_1", int'(light_a), int'(RED));
        cycle(1'b0, 0, 0);
        check("green_after_2", int'(light_a), int'(GREEN));
        for (int i = 0; i < 100; i++) cycle(1'b0, 0, 0);

        // Max-green run: lane A stays green exactly MAX_G cycles.
        cycle(1'b1, 5, 2);
        while (ph != 0) cycle(1'b0, 5, 2);
        green_cycles_a = 1;
        for (int i = 0; i < 40 && ph == 0; i++) begin
            cycle(1'b0, 5, 2);
            if (int'(light_a) == int'(GREEN)) green_cycles_a++;
        end
        check("max_green_len", green_cycles_a, MAX_G);

        for (int seg = 0; seg < 90; seg++) begin
            ca = rand_count();
            cb = rand_count();
            len = int'($urandom_range(1, 60));
            if ($urandom_range(0, 15) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) cycle(1'b1, ca, cb);
            end
            for (int k = 0; k < len; k++) cycle(1'b0, ca, cb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
